// File: rtl/medidor_pwm_3.sv
// PWM receiver: measures high time and period of pwm_in and decodes the 3-bit width code.
// Emits a one-cycle valido with the decoded code, or a one-cycle erro for unmatched waveforms.
module medidor_pwm_3 #(
  parameter int unsigned conf_periodo = 1250,
  parameter int unsigned largura_000  = 0,
  parameter int unsigned largura_001  = 50,
  parameter int unsigned largura_010  = 100,
  parameter int unsigned largura_011  = 200,
  parameter int unsigned largura_100  = 350,
  parameter int unsigned largura_101  = 500,
  parameter int unsigned largura_110  = 750,
  parameter int unsigned largura_111  = 1000,
  parameter int unsigned tolerancia   = 20,
  parameter int unsigned timeout      = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [2:0]  codigo,
  output logic        valido,
  output logic        erro,
  output logic [31:0] medida_alto
);

  typedef enum logic [1:0] {ESPERA, ALTO, BAIXO} estado_t;

  localparam logic [31:0] TMO = 32'(timeout);
  localparam logic [31:0] TOL = 32'(tolerancia);
  localparam logic [31:0] PER = 32'(conf_periodo);
  localparam logic [7:0][31:0] LARG = {
    32'(largura_111), 32'(largura_110), 32'(largura_101), 32'(largura_100),
    32'(largura_011), 32'(largura_010), 32'(largura_001), 32'(largura_000)};

  function automatic logic [31:0] dif(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] c);
    return (c >= TMO) ? TMO : (c + 32'd1);
  endfunction

  estado_t     estado_q, estado_d;
  logic        sync1_q, s_q, s_d_q;
  logic [31:0] cont_alto_q, cont_alto_d;
  logic [31:0] cont_periodo_q, cont_periodo_d;
  logic [31:0] cont_baixo_q, cont_baixo_d;
  logic [2:0]  codigo_q, codigo_d;
  logic        valido_q, valido_d;
  logic        erro_q, erro_d;
  logic [31:0] medida_alto_q, medida_alto_d;

  logic        subida, descida;
  logic        achou;
  logic [2:0]  cod_achado;
  logic        periodo_ok;

  assign subida  = s_q & ~s_d_q;
  assign descida = ~s_q & s_d_q;

  // Lowest matching code wins: scan downward so the last hit is the smallest k.
  always_comb begin
    achou      = 1'b0;
    cod_achado = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (dif(cont_alto_q, LARG[k]) <= TOL) begin
        achou      = 1'b1;
        cod_achado = 3'(k);
      end
    end
  end

  assign periodo_ok = dif(cont_periodo_q, PER) <= TOL;

  always_comb begin
    estado_d       = estado_q;
    cont_alto_d    = cont_alto_q;
    cont_periodo_d = cont_periodo_q;
    cont_baixo_d   = cont_baixo_q;
    codigo_d       = codigo_q;
    medida_alto_d  = medida_alto_q;
    valido_d       = 1'b0;
    erro_d         = 1'b0;
    case (estado_q)
      ESPERA: begin
        cont_baixo_d = s_q ? 32'd0 : inc_sat(cont_baixo_q);
        if (subida) begin
          estado_d       = ALTO;
          cont_alto_d    = 32'd1;
          cont_periodo_d = 32'd1;
        end else if (cont_baixo_q == TMO) begin
          valido_d      = 1'b1;
          codigo_d      = 3'd0;
          medida_alto_d = 32'd0;
          cont_baixo_d  = 32'd0;
        end
      end
      ALTO: begin
        cont_periodo_d = inc_sat(cont_periodo_q);
        if (cont_alto_q == TMO) begin
          erro_d       = 1'b1;
          estado_d     = ESPERA;
          cont_baixo_d = 32'd0;
        end else if (descida) begin
          // The falling-edge cycle is already low time: period counts it, high time does not.
          estado_d = BAIXO;
        end else begin
          cont_alto_d = inc_sat(cont_alto_q);
        end
      end
      BAIXO: begin
        cont_periodo_d = inc_sat(cont_periodo_q);
        if (subida) begin
          if (periodo_ok && achou) begin
            valido_d      = 1'b1;
            codigo_d      = cod_achado;
            medida_alto_d = cont_alto_q;
          end else begin
            erro_d = 1'b1;
          end
          estado_d       = ALTO;
          cont_alto_d    = 32'd1;
          cont_periodo_d = 32'd1;
        end else if (cont_periodo_q == TMO) begin
          valido_d      = 1'b1;
          codigo_d      = 3'd0;
          medida_alto_d = 32'd0;
          cont_baixo_d  = 32'd0;
          estado_d      = ESPERA;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q        <= 1'b0;
      s_q            <= 1'b0;
      s_d_q          <= 1'b0;
      estado_q       <= ESPERA;
      cont_alto_q    <= 32'd0;
      cont_periodo_q <= 32'd0;
      cont_baixo_q   <= 32'd0;
      codigo_q       <= 3'd0;
      valido_q       <= 1'b0;
      erro_q         <= 1'b0;
      medida_alto_q  <= 32'd0;
    end else begin
      sync1_q        <= pwm_in;
      s_q            <= sync1_q;
      s_d_q          <= s_q;
      estado_q       <= estado_d;
      cont_alto_q    <= cont_alto_d;
      cont_periodo_q <= cont_periodo_d;
      cont_baixo_q   <= cont_baixo_d;
      codigo_q       <= codigo_d;
      valido_q       <= valido_d;
      erro_q         <= erro_d;
      medida_alto_q  <= medida_alto_d;
    end
  end

  assign codigo      = codigo_q;
  assign valido      = valido_q;
  assign erro        = erro_q;
  assign medida_alto = medida_alto_q;

endmodule

// File: tb/tb_medidor_pwm_3.sv
// Directed bench for medidor_pwm_3: drives PWM periods back-to-back and checks
// strobe counts, decoded codes and measured high times against hand-computed values.
module tb_medidor_pwm_3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pwm_in = 1'b0;
  logic [2:0]  codigo;
  logic        valido;
  logic        erro;
  logic [31:0] medida_alto;

  int n_cmp = 0;
  int n_err = 0;
  int nv = 0, ne = 0;
  int n_dupla = 0, n_junto = 0;
  logic valido_ant = 1'b0, erro_ant = 1'b0;

  medidor_pwm_3 dut (
    .clock       (clock),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .codigo      (codigo),
    .valido      (valido),
    .erro        (erro),
    .medida_alto (medida_alto)
  );

  always #5 clock = ~clock;

  // Strobe monitor: counts pulses, flags multi-cycle or simultaneous strobes.
  always @(negedge clock) begin
    if (valido) nv++;
    if (erro) ne++;
    if (valido && erro) n_junto++;
    if ((valido && valido_ant) || (erro && erro_ant)) n_dupla++;
    valido_ant = valido;
    erro_ant   = erro;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; returns at the same phase.
  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic periodo(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  initial begin
    #3 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_codigo", 32'(codigo), 0);
    chk("reset_valido", 32'(valido), 0);
    chk("reset_erro", 32'(erro), 0);
    chk("reset_medida", medida_alto, 0);
    reset = 1'b0;
    drive(1'b0, 10);

    // 1: code 100 repeated; first edge only starts measuring
    periodo(350, 1250);
    chk("t1_no_strobe_first", 32'(nv), 0);
    periodo(350, 1250);
    periodo(350, 1250);
    chk("t1_nvalido", 32'(nv), 2);
    chk("t1_codigo", 32'(codigo), 4);
    chk("t1_medida", medida_alto, 350);

    // 2: 1000 -> 111, then 55 -> 001
    periodo(1000, 1250);
    periodo(55, 1250);
    chk("t2_nvalido_a", 32'(nv), 4);
    chk("t2_codigo_111", 32'(codigo), 7);
    chk("t2_medida_1000", medida_alto, 1000);
    // 3: 160 matches no code
    periodo(160, 1250);
    chk("t2_codigo_001", 32'(codigo), 1);
    chk("t2_medida_55", medida_alto, 55);
    chk("t2_nerro", 32'(ne), 0);

    // 4: wrong period -> erro each period, then low timeout -> 000
    periodo(350, 1000);
    chk("t3_nerro", 32'(ne), 1);
    chk("t3_nvalido", 32'(nv), 5);
    chk("t3_codigo_kept", 32'(codigo), 1);
    chk("t3_medida_kept", medida_alto, 55);
    periodo(350, 1000);
    chk("t4_nerro", 32'(ne), 2);
    drive(1'b0, 2000);
    chk("t4_timeout_nvalido", 32'(nv), 6);
    chk("t4_timeout_codigo", 32'(codigo), 0);
    chk("t4_timeout_medida", medida_alto, 0);
    chk("t4_timeout_nerro", 32'(ne), 2);

    // 5: stuck high -> single erro, then recovers after two edges
    drive(1'b1, 2600);
    chk("t5_stuck_nerro", 32'(ne), 3);
    chk("t5_stuck_nvalido", 32'(nv), 6);
    drive(1'b0, 100);
    periodo(200, 1250);
    chk("t5_first_edge_nvalido", 32'(nv), 6);
    periodo(200, 1250);
    chk("t5_nvalido", 32'(nv), 7);
    chk("t5_codigo", 32'(codigo), 3);
    chk("t5_medida", medida_alto, 200);

    // 6: reset while high aborts; new decode needs a full period
    drive(1'b1, 100);
    chk("t6_pre_nvalido", 32'(nv), 8);
    reset = 1'b1;
    #1;
    chk("t6_rst_codigo", 32'(codigo), 0);
    chk("t6_rst_medida", medida_alto, 0);
    chk("t6_rst_valido", 32'(valido), 0);
    chk("t6_rst_erro", 32'(erro), 0);
    pwm_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b0, 20);
    periodo(500, 1250);
    chk("t6_first_nvalido", 32'(nv), 8);
    periodo(500, 1250);
    chk("t6_nvalido", 32'(nv), 9);
    chk("t6_codigo", 32'(codigo), 5);
    chk("t6_medida", medida_alto, 500);
    chk("t6_nerro", 32'(ne), 3);
    drive(1'b0, 10);

    chk("strobe_one_cycle", 32'(n_dupla), 0);
    chk("strobe_exclusive", 32'(n_junto), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
